// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1001 sequence detector family and its consumers.
package seq_det_pkg;

    localparam int unsigned CNT_W_DEF      = 5;
    localparam int unsigned ID_W_DEF       = 8;
    localparam int unsigned RES_FIFO_DEPTH = 2;
    localparam int unsigned DROP_W         = 8;

    // Window phase: CLOSE is a zero-length phase decoded on the closing sample.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_CLOSE = 1'b1
    } win_state_e;

    // Per-window result at the family default widths.
    typedef struct packed {
        logic [ID_W_DEF-1:0]  win_id;
        logic [CNT_W_DEF-1:0] count;
    } match_res_t;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/seq_match_window_cnt_res_fifo2.sv
// Two-entry show-ahead result FIFO; the head is held in a register so the
// outputs carry no combinational path from push/pop.
module res_fifo2
    import seq_det_pkg::*;
#(
    parameter type T = match_res_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_valid,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned OCC_W = $clog2(RES_FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RES_FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    T                 r_head;
    T                 r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             r_valid;
    logic             r_full;

    T                 w_head_nxt;
    T                 w_tail_nxt;
    logic [OCC_W-1:0] w_occ_nxt;
    logic             w_pop;
    logic             w_push;

    // Pop only a valid head; a push is accepted unless full with no pop.
    assign w_pop  = i_pop && r_valid;
    assign w_push = i_push && (!r_full || w_pop);

    // Next head/tail/occupancy for each push/pop combination.
    always_comb begin
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        w_occ_nxt  = r_occ;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_occ == '0) begin
                    w_head_nxt = i_data;
                end else begin
                    w_tail_nxt = i_data;
                end
                w_occ_nxt = r_occ + OCC_ONE;
            end
            2'b01: begin
                w_head_nxt = r_tail;
                w_occ_nxt  = r_occ - OCC_ONE;
            end
            2'b11: begin
                if (r_occ == OCC_ONE) begin
                    w_head_nxt = i_data;
                end else begin
                    w_head_nxt = r_tail;
                    w_tail_nxt = i_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != '0);
            r_full  <= (w_occ_nxt == OCC_FULL);
        end
    end

    assign o_data  = r_head;
    assign o_valid = r_valid;
    assign o_full  = r_full;
    assign o_empty = !r_valid;

endmodule

// File: rtl/seq_match_window_cnt.sv
// Counts detector match pulses over windows of WIN enabled samples and
// queues one {window id, count} result per window.
module seq_match_window_cnt
    import seq_det_pkg::*;
#(
    parameter int unsigned WIN   = 16,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [ID_W-1:0]   out_win_id,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned IDX_W = $clog2(WIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [ID_W-1:0]  win_id;
        logic [CNT_W-1:0] count;
    } res_t;

    logic [IDX_W-1:0]  r_bit_idx;
    logic [CNT_W-1:0]  r_acc;
    logic [ID_W-1:0]   r_win_id;
    logic [DROP_W-1:0] r_drop_cnt;

    win_state_e        w_state;
    logic [IDX_W-1:0]  w_bit_idx_nxt;
    logic [CNT_W-1:0]  w_acc_nxt;
    logic [ID_W-1:0]   w_win_id_nxt;
    logic [DROP_W-1:0] w_drop_cnt_nxt;
    logic [CNT_W-1:0]  w_acc_sum;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_valid;
    logic              w_drop;
    res_t              w_res;
    res_t              w_head;

    // Accumulator plus the current sample, holding at the saturation value.
    assign w_acc_sum = (r_acc == CNT_MAX) ? r_acc : r_acc + CNT_W'(z);

    // CLOSE is decoded on the enabled sample that ends the window.
    assign w_state = (en && (r_bit_idx == LAST_IDX)) ? ST_CLOSE : ST_ACCUM;

    // Window next-state: accumulate, or emit the result and start a new window.
    always_comb begin
        w_bit_idx_nxt = r_bit_idx;
        w_acc_nxt     = r_acc;
        w_win_id_nxt  = r_win_id;
        w_push        = 1'b0;
        if (en) begin
            case (w_state)
                ST_ACCUM: begin
                    w_acc_nxt     = w_acc_sum;
                    w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                end
                ST_CLOSE: begin
                    w_push        = 1'b1;
                    w_acc_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_win_id_nxt  = r_win_id + ID_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign w_res.win_id = r_win_id;
    assign w_res.count  = w_acc_sum;

    // A full FIFO only loses the result when the head is not leaving this cycle.
    assign w_pop  = !w_empty && out_ready;
    assign w_drop = w_push && w_full && !w_pop;

    // Drop counter next value.
    always_comb begin
        w_drop_cnt_nxt = r_drop_cnt;
        if (w_drop) begin
            w_drop_cnt_nxt = sat_inc_drop(r_drop_cnt);
        end
    end

    // Window and drop state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_idx  <= '0;
            r_acc      <= '0;
            r_win_id   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_bit_idx  <= w_bit_idx_nxt;
            r_acc      <= w_acc_nxt;
            r_win_id   <= w_win_id_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    res_fifo2 #(
        .T (res_t)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (w_res),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid  = w_valid;
    assign out_count  = w_head.count;
    assign out_win_id = w_head.win_id;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_seq_match_window_cnt.sv
// Bench for seq_match_window_cnt: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_seq_match_window_cnt;

    localparam int WIN   = 8;
    localparam int CNT_W = 2;
    localparam int ID_W  = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             z;
    logic             out_ready;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic [ID_W-1:0]  out_win_id;
    logic [7:0]       drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    typedef struct {
        int id;
        int cnt;
    } res_m_t;

    res_m_t m_q[$];
    res_m_t m_res;
    int     m_idx;
    int     m_hits;
    int     m_id;
    int     m_drop;
    bit     m_pop;
    bit     m_push;

    seq_match_window_cnt #(
        .WIN   (WIN),
        .CNT_W (CNT_W),
        .ID_W  (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .z          (z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_win_id (out_win_id),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count enabled samples and hits per window, saturate the total,
    // and keep a two-deep queue with drop accounting.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idx  = 0;
            m_hits = 0;
            m_id   = 0;
            m_drop = 0;
            m_q.delete();
        end else begin
            m_pop  = (m_q.size() != 0) && (out_ready == 1'b1);
            m_push = 1'b0;
            if (en == 1'b1) begin
                if (z == 1'b1) m_hits++;
                m_idx++;
                if (m_idx == WIN) begin
                    m_push    = 1'b1;
                    m_res.id  = m_id;
                    m_res.cnt = (m_hits > CMAX) ? CMAX : m_hits;
                    m_id      = (m_id + 1) % (1 << ID_W);
                    m_idx     = 0;
                    m_hits    = 0;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < 2) m_q.push_back(m_res);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (m_q.size() != 0) begin
                chk("cyc_valid", int'(out_valid), 1);
                chk("cyc_count", int'(out_count), m_q[0].cnt);
                chk("cyc_win_id", int'(out_win_id), m_q[0].id);
            end else begin
                chk("cyc_valid", int'(out_valid), 0);
            end
            chk("cyc_drop", int'(drop_cnt), m_drop);
        end
    end

    task automatic cyc(input logic e, input logic zz, input logic rdy);
        en        = e;
        z         = zz;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        z         = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        z         = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_win_id", int'(out_win_id), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        rst    = 1'b1;
        cmp_en = 1'b1;

        // Basic count: hits on samples 3 and 6.
        for (int s = 0; s < WIN; s++) begin
            cyc(1'b1, (s == 3 || s == 6), 1'b1);
            if (s == WIN - 2) chk("basic_not_early", int'(out_valid), 0);
        end
        chk("basic_valid", int'(out_valid), 1);
        chk("basic_count", int'(out_count), 2);
        chk("basic_win_id", int'(out_win_id), 0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("basic_one_cycle", int'(out_valid), 0);

        // Boundary pulse with z high during disabled cycles.
        for (int s = 0; s < 4; s++) cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        for (int s = 4; s < WIN - 1; s++) cyc(1'b1, 1'b0, 1'b1);
        chk("gate_not_early", int'(out_valid), 0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("gate_valid", int'(out_valid), 1);
        chk("gate_count", int'(out_count), 1);
        chk("gate_win_id", int'(out_win_id), 1);
        cyc(1'b0, 1'b0, 1'b1);

        // Saturation: every sample hits.
        for (int s = 0; s < WIN; s++) cyc(1'b1, 1'b1, 1'b1);
        chk("sat_count", int'(out_count), CMAX);
        chk("sat_win_id", int'(out_win_id), 2);
        cyc(1'b0, 1'b0, 1'b1);

        // Backpressure across three windows; the third is dropped.
        do_reset();
        for (int w = 0; w < 3; w++)
            for (int s = 0; s < WIN; s++)
                cyc(1'b1, (w == 0 && s == 0) || (w == 1 && s < 2), 1'b0);
        chk("bp_drop", int'(drop_cnt), 1);
        chk("bp_model_drop", m_drop, 1);
        chk("bp_head_id", int'(out_win_id), 0);
        chk("bp_head_count", int'(out_count), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("bp_second_id", int'(out_win_id), 1);
        chk("bp_second_count", int'(out_count), 2);
        cyc(1'b0, 1'b0, 1'b1);
        chk("bp_drained", int'(out_valid), 0);
        for (int s = 0; s < WIN; s++) cyc(1'b1, (s == 4), 1'b1);
        chk("bp_next_id", int'(out_win_id), 3);
        chk("bp_next_count", int'(out_count), 1);
        cyc(1'b0, 1'b0, 1'b1);

        // Full FIFO with pop on the closing edge of window 2.
        do_reset();
        for (int w = 0; w < 3; w++)
            for (int s = 0; s < WIN; s++)
                cyc(1'b1, (w == 0 && s == 5) || (w == 1 && (s == 1 || s == 2)) || (w == 2),
                    (w == 2 && s == WIN - 1));
        chk("full_no_drop", int'(drop_cnt), 0);
        chk("full_head_id", int'(out_win_id), 1);
        chk("full_head_count", int'(out_count), 2);
        cyc(1'b0, 1'b0, 1'b1);
        chk("full_next_id", int'(out_win_id), 2);
        chk("full_next_count", int'(out_count), CMAX);
        cyc(1'b0, 1'b0, 1'b1);
        chk("full_drained", int'(out_valid), 0);

        // Asynchronous reset mid-window with one result queued.
        do_reset();
        for (int s = 0; s < WIN; s++) cyc(1'b1, (s == 2), 1'b0);
        for (int s = 0; s < 4; s++) cyc(1'b1, (s == 1), 1'b0);
        chk("ar_queued", int'(out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid_now", int'(out_valid), 0);
        chk("ar_count_now", int'(out_count), 0);
        chk("ar_win_id_now", int'(out_win_id), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int s = 0; s < WIN; s++) cyc(1'b1, (s == 2), 1'b1);
        chk("ar_after_id", int'(out_win_id), 0);
        chk("ar_after_count", int'(out_count), 1);
        cyc(1'b0, 1'b0, 1'b1);

        // Randomized traffic with varying backpressure and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 200) % 3 == 0) ? 10 : (((i / 200) % 3 == 1) ? 50 : 95);
            if ($urandom_range(799, 0) == 0) do_reset();
            cyc(($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 3),
                ($urandom_range(99, 0) < rdy_pct));
        end

        // Long stall drives the drop counter into saturation.
        for (int i = 0; i < 2200; i++) cyc(1'b1, ($urandom_range(1, 0) == 1), 1'b0);
        chk("drop_sat", int'(drop_cnt), 255);
        chk("drop_sat_model", m_drop, 255);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        chk("final_drained", int'(out_valid), 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
